// File: rtl/risk_sequencer.sv
// risk_sequencer: expands one tiled load/store descriptor into a run of
// risk ops, each held HOLD cycles, with done/aborted status at the end.
module risk_sequencer #(
  parameter int FUNC_W   = 3,
  parameter int REG_W    = 5,
  parameter int ADDR_W   = 17,
  parameter int STRIDE_W = 15,
  parameter int CNT_W    = 8,
  parameter int HOLD     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [FUNC_W-1:0]   cmd_func,
  input  logic [REG_W-1:0]    cmd_reg,
  input  logic [REG_W-1:0]    cmd_reg_step,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [ADDR_W-1:0]   cmd_addr_step,
  input  logic [STRIDE_W-1:0] cmd_stride_x,
  input  logic [STRIDE_W-1:0] cmd_stride_y,
  input  logic [CNT_W-1:0]    cmd_count,
  input  logic                abort,
  output logic [FUNC_W-1:0]   risk_func,
  output logic [REG_W-1:0]    risk_reg,
  output logic [ADDR_W-1:0]   risk_addr,
  output logic [STRIDE_W-1:0] risk_stride_x,
  output logic [STRIDE_W-1:0] risk_stride_y,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]          r_state;
  logic [FUNC_W-1:0]   r_func;
  logic [REG_W-1:0]    r_reg;
  logic [REG_W-1:0]    r_reg_step;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_addr_step;
  logic [STRIDE_W-1:0] r_sx;
  logic [STRIDE_W-1:0] r_sy;
  logic [CNT_W-1:0]    r_remain;
  logic [HW-1:0]       r_hold;
  logic                r_busy;
  logic                r_done;
  logic                r_aborted;
  logic                w_accept;
  logic                w_op_end;

  assign cmd_ready = (r_state == S_IDLE) && !reset;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_op_end  = (r_hold == '0);

  assign risk_func     = r_func;
  assign risk_reg      = r_reg;
  assign risk_addr     = r_addr;
  assign risk_stride_x = r_sx;
  assign risk_stride_y = r_sy;
  assign busy          = r_busy;
  assign done          = r_done;
  assign aborted       = r_aborted;

  // Sequencer FSM: latch descriptor, step running adders, emit done status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_func      <= '0;
      r_reg       <= '0;
      r_reg_step  <= '0;
      r_addr      <= '0;
      r_addr_step <= '0;
      r_sx        <= '0;
      r_sy        <= '0;
      r_remain    <= '0;
      r_hold      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done    <= 1'b0;
          r_aborted <= 1'b0;
          if (w_accept) begin
            r_busy      <= 1'b1;
            r_reg_step  <= cmd_reg_step;
            r_addr_step <= cmd_addr_step;
            r_hold      <= HOLD_M1;
            if (cmd_count == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_ISSUE;
              r_func   <= cmd_func;
              r_reg    <= cmd_reg;
              r_addr   <= cmd_addr;
              r_sx     <= cmd_stride_x;
              r_sy     <= cmd_stride_y;
              r_remain <= cmd_count - 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (abort || (w_op_end && r_remain == '0)) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_aborted <= abort;
            r_func    <= '0;
            r_reg     <= '0;
            r_addr    <= '0;
            r_sx      <= '0;
            r_sy      <= '0;
          end else if (w_op_end) begin
            r_reg    <= r_reg + r_reg_step;
            r_addr   <= r_addr + r_addr_step;
            r_remain <= r_remain - 1'b1;
            r_hold   <= HOLD_M1;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_aborted <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
